// File: rtl/temp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : temp_pkg                                             |
// | Description : Shared widths, default parameter values and FSM      |
// |               state encodings for the temperature sample scheduler |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package temp_pkg;

    // Data path widths
    localparam int c_ADC_W  = 16;
    localparam int c_TEMP_W = 32;
    localparam int c_ACC_W  = 35;

    // Default parameter values
    localparam int c_SAMPLE_PERIOD_DEF = 1000;
    localparam int c_ADC_TIMEOUT_DEF   = 255;
    localparam int c_AVG_LOG2_DEF      = 2;

    // Scheduler FSM state encodings
    localparam int         c_STATE_W    = 3;
    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_START    = 3'd1;
    localparam logic [2:0] c_ST_WAIT_ADC = 3'd2;
    localparam logic [2:0] c_ST_SETTLE   = 3'd3;
    localparam logic [2:0] c_ST_ACCUM    = 3'd4;
    localparam logic [2:0] c_ST_DONE     = 3'd5;

endpackage
`default_nettype wire

// File: rtl/temp_period_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : temp_period_timer                                    |
// | Description : Free-running period counter producing a one-cycle    |
// |               tick every SAMPLE_PERIOD cycles while enabled        |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module temp_period_timer
    import temp_pkg::*;
#(
    parameter int SAMPLE_PERIOD = c_SAMPLE_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    output logic o_tick
);

    localparam int                c_CNT_W = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(SAMPLE_PERIOD - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Count while enabled, wrap on the last count, hold at zero when disabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_enable || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_enable && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/temp_sample_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : temp_sample_scheduler                                |
// | Description : Triggers ADC conversions, feeds each word to the     |
// |               temperature calculator, averages a burst of results  |
// |               and publishes one registered temperature             |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module temp_sample_scheduler
    import temp_pkg::*;
#(
    parameter int SAMPLE_PERIOD = c_SAMPLE_PERIOD_DEF,
    parameter int ADC_TIMEOUT   = c_ADC_TIMEOUT_DEF,
    parameter int AVG_LOG2      = c_AVG_LOG2_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                start_single,
    input  logic                err_clr,
    output logic                adc_start,
    input  logic                adc_done,
    input  logic [c_ADC_W-1:0]  adc_data_in,
    output logic [c_ADC_W-1:0]  calc_adc_data,
    input  logic [c_TEMP_W-1:0] calc_tempc,
    output logic [c_TEMP_W-1:0] temp_out,
    output logic                temp_valid,
    output logic                busy,
    output logic                timeout_err,
    output logic                overrun_err
);

    localparam int               c_TO_W   = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT + 1) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(ADC_TIMEOUT - 1);
    localparam logic [3:0]       c_BURST  = 4'(1 << AVG_LOG2);

    logic [c_STATE_W-1:0]       r_state;
    logic [c_TO_W-1:0]          r_to_cnt;
    logic [3:0]                 r_burst;
    logic signed [c_ACC_W-1:0]  r_acc;
    logic [c_ADC_W-1:0]         r_calc_adc_data;
    logic [c_TEMP_W-1:0]        r_temp_out;
    logic                       r_adc_start;
    logic                       r_temp_valid;
    logic                       r_busy;
    logic                       r_timeout_err;
    logic                       r_overrun_err;

    logic                       w_tick;
    logic                       w_trigger;
    logic                       w_timeout_hit;
    logic signed [c_ACC_W-1:0]  w_acc_next;

    temp_period_timer #(
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_enable (enable),
        .o_tick   (w_tick)
    );

    // A tick and a single request in the same cycle are one trigger
    assign w_trigger     = w_tick | start_single;
    assign w_timeout_hit = (r_state == c_ST_WAIT_ADC) && !adc_done && (r_to_cnt == c_TO_LAST);
    assign w_acc_next    = r_acc + {{(c_ACC_W - c_TEMP_W){calc_tempc[c_TEMP_W-1]}}, calc_tempc};

    // Burst sequencer: request, wait, settle, accumulate, publish
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= c_ST_IDLE;
            r_to_cnt        <= '0;
            r_burst         <= '0;
            r_acc           <= '0;
            r_calc_adc_data <= '0;
            r_temp_out      <= '0;
            r_adc_start     <= 1'b0;
            r_temp_valid    <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_adc_start  <= 1'b0;
            r_temp_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_trigger) begin
                        r_state     <= c_ST_START;
                        r_acc       <= '0;
                        r_burst     <= '0;
                        r_adc_start <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                c_ST_START: begin
                    r_state  <= c_ST_WAIT_ADC;
                    r_to_cnt <= '0;
                end
                c_ST_WAIT_ADC: begin
                    if (adc_done) begin
                        r_calc_adc_data <= adc_data_in;
                        r_state         <= c_ST_SETTLE;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                c_ST_SETTLE: begin
                    r_state <= c_ST_ACCUM;
                end
                c_ST_ACCUM: begin
                    r_acc   <= w_acc_next;
                    r_burst <= r_burst + 1'b1;
                    if ((r_burst + 1'b1) == c_BURST) begin
                        // Arithmetic shift floors toward minus infinity
                        r_temp_out   <= c_TEMP_W'(w_acc_next >>> AVG_LOG2);
                        r_temp_valid <= 1'b1;
                        r_state      <= c_ST_DONE;
                    end else begin
                        r_adc_start <= 1'b1;
                        r_state     <= c_ST_START;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags; a new event wins over a clear in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            if (w_timeout_hit) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end
            if (w_trigger && (r_state != c_ST_IDLE)) begin
                r_overrun_err <= 1'b1;
            end else if (err_clr) begin
                r_overrun_err <= 1'b0;
            end
        end
    end

    assign adc_start     = r_adc_start;
    assign calc_adc_data = r_calc_adc_data;
    assign temp_out      = r_temp_out;
    assign temp_valid    = r_temp_valid;
    assign busy          = r_busy;
    assign timeout_err   = r_timeout_err;
    assign overrun_err   = r_overrun_err;

endmodule
`default_nettype wire
